// File: rtl/uart_rx_if.sv
// Receive-side bundle from the UART rx engine to the control block.
// The rx engine drives it through master; consumers use slave.
interface uart_rx_if;
  logic       rx_busy;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_perr;

  modport master (
    output rx_busy, rx_end, rx_data, rx_ferr, rx_perr
  );

  modport slave (
    input rx_busy, rx_end, rx_data, rx_ferr, rx_perr
  );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receive engine: 2-flop sync, mid-bit sampling, break hold-off.
// Define UART_RX_PARITY_EN to insert an even-parity bit before stop.
module uart_rx #(
  parameter int DIV_RATE  = 260,
  parameter int DIV_CNT_W = 9
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master rx_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_e;

  localparam logic [DIV_CNT_W-1:0] HALF_M1 =
    DIV_CNT_W'(DIV_RATE / 2 - 1);
  localparam logic [DIV_CNT_W-1:0] FULL_M1 =
    DIV_CNT_W'(DIV_RATE - 1);

  state_e               state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 busy_q;
  logic                 end_q, end_d;
  logic [7:0]           data_q, data_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    end_d     = 1'b0;
    data_d    = data_q;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (div_cnt_q == HALF_M1) begin
          state_d   = rx_s_q ? IDLE : DATA;
          bit_cnt_d = 3'd0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end
      DATA: begin
        if (div_cnt_q == FULL_M1) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (div_cnt_q == FULL_M1) begin
          par_d   = (^shift_q) ^ rx_s_q;
          state_d = STOP;
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (div_cnt_q == FULL_M1) begin
          end_d   = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_q;
`endif
          // A low stop bit parks in BRK so a held line is not a new start
          state_d = rx_s_q ? IDLE : BRK;
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      data_q    <= 8'h00;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= (state_q != IDLE);
      end_q     <= end_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_q     <= par_d;
`endif
    end
  end

  assign rx_o.rx_busy = busy_q;
  assign rx_o.rx_end  = end_q;
  assign rx_o.rx_data = data_q;
  assign rx_o.rx_ferr = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_o.rx_perr = perr_q;
`else
  assign rx_o.rx_perr = 1'b0;
`endif

endmodule
